// File: rtl/i4004_pkg.sv
// Shared 4004 bus definitions: the bus-phase enum, the opcodes a ROM responder
// decodes, and nibble/byte typedefs. Also used by the CPU bench.
package i4004_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_A1   = 4'd1,
    PH_A2   = 4'd2,
    PH_A3   = 4'd3,
    PH_M1   = 4'd4,
    PH_M2   = 4'd5,
    PH_X1   = 4'd6,
    PH_X2   = 4'd7,
    PH_X3   = 4'd8
  } phase_e;

  // SRC is matched on OPR together with OPA[0]=1. WRR and RDR are full bytes.
  localparam nibble_t OPR_SRC = 4'h2;
  localparam byte_t   OP_WRR  = 8'hE2;
  localparam byte_t   OP_RDR  = 8'hEA;

endpackage

// File: rtl/i4004_phase_tracker.sv
// Tracks the 8-phase 4004 instruction cycle from clk2_pad and sync_pad in the
// sysclk domain. A RAM responder can reuse it unchanged.
module i4004_phase_tracker
  import i4004_pkg::*;
(
  input  logic   sysclk,
  input  logic   reset_n,
  input  logic   clk2_pad,
  input  logic   sync_pad,
  output logic   ph_stb,
  output phase_e state,
  output logic   sync_err
);

  logic [2:0] c2_sr;
  phase_e     state_nx;
  logic       lost_sync;

  // Two flops synchronise clk2_pad. The third flop is used only to find the edge.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) c2_sr <= '0;
    else          c2_sr <= {c2_sr[1:0], clk2_pad};
  end

  assign ph_stb = c2_sr[1] & ~c2_sr[2];

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PH_IDLE;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nx;
      sync_err <= lost_sync;
    end
  end

  always_comb begin
    state_nx  = state;
    lost_sync = 1'b0;
    if (ph_stb) begin
      case (state)
        PH_IDLE: if (sync_pad) state_nx = PH_A1;
        PH_A1:   state_nx = PH_A2;
        PH_A2:   state_nx = PH_A3;
        PH_A3:   state_nx = PH_M1;
        PH_M1:   state_nx = PH_M2;
        PH_M2:   state_nx = PH_X1;
        PH_X1:   state_nx = PH_X2;
        PH_X2:   state_nx = PH_X3;
        PH_X3: begin
          state_nx  = sync_pad ? PH_A1 : PH_IDLE;
          lost_sync = ~sync_pad;
        end
        default: state_nx = PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i4001_rom_responder.sv
// 4001-style ROM responder. It captures the 12-bit fetch address and returns
// the opcode nibbles in M1/M2 when this chip is selected.
// Defining ROM_IO_PORT_EN adds the 4-bit I/O port (SRC/WRR/RDR in X2).
module i4001_rom_responder
  import i4004_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter int         DEPTH   = 256
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       clk1_pad,
  input  logic       clk2_pad,
  input  logic       sync_pad,
  input  logic       cmrom_pad,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic [3:0] phase,
`ifdef ROM_IO_PORT_EN
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
`endif
  output logic       sync_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  phase_e  state;
  logic    ph_stb;
  logic [11:0] addr;
  logic    sel_cm;
  logic    selected;
  byte_t   out_byte;
  nibble_t opr, opa;
  byte_t   rom [DEPTH];

  i4004_phase_tracker u_trk (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .clk2_pad (clk2_pad),
    .sync_pad (sync_pad),
    .ph_stb   (ph_stb),
    .state    (state),
    .sync_err (sync_err)
  );

  // Reset does not clear the preload contents.
  always_ff @(posedge sysclk) begin
    if (load_en) rom[load_addr[AW-1:0]] <= load_data;
  end

  // The output byte is read once, at the end of A3. A preload write during
  // M1/M2 therefore cannot change the byte being served.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      addr     <= '0;
      sel_cm   <= 1'b0;
      out_byte <= '0;
      opr      <= '0;
      opa      <= '0;
    end else if (ph_stb) begin
      case (state)
        PH_A1: addr[3:0] <= data_in;
        PH_A2: addr[7:4] <= data_in;
        PH_A3: begin
          addr[11:8] <= data_in;
          sel_cm     <= cmrom_pad;
          out_byte   <= rom[addr[AW-1:0]];
        end
        PH_M1: opr <= data_in;
        PH_M2: opa <= data_in;
        default: ;
      endcase
    end
  end

  assign selected = sel_cm && (addr[11:8] == CHIP_ID);
  assign phase    = state;

`ifdef ROM_IO_PORT_EN
  nibble_t src_chip;
  logic    rdr_hit;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      src_chip <= '0;
      io_out   <= '0;
    end else if (ph_stb && state == PH_X2) begin
      if (opr == OPR_SRC && opa[0] && cmrom_pad) src_chip <= data_in;
      if ({opr, opa} == OP_WRR && src_chip == CHIP_ID) io_out <= data_in;
    end
  end

  assign rdr_hit = ({opr, opa} == OP_RDR) && (src_chip == CHIP_ID);

  logic unused_ok;
  assign unused_ok = clk1_pad;
`else
  logic unused_ok;
  assign unused_ok = ^{clk1_pad, opr, opa};
`endif

  always_comb begin
    data_oe  = 1'b0;
    data_out = 4'h0;
    if (selected && state == PH_M1) begin
      data_oe  = 1'b1;
      data_out = out_byte[7:4];
    end else if (selected && state == PH_M2) begin
      data_oe  = 1'b1;
      data_out = out_byte[3:0];
    end
`ifdef ROM_IO_PORT_EN
    else if (rdr_hit && state == PH_X2) begin
      data_oe  = 1'b1;
      data_out = io_in;
    end
`endif
  end

endmodule
